mode_counter: RTL

Parametrised successor to the project's single-mode 13-bit counter. Provides a WIDTH-bit up/down counter with a loadable start value, selectable wrap or stop-at-terminal mode, level-sensitive pause, and an enable prescaler. It sits between the game control FSM (go/hold/mode) and the score/timer display logic (count, tc, done).

---
 rtl/counter_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 42 ++++
 rtl/mode_counter.sv | 109 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state and direction definitions for mode_counter
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides advance cycles into one tick per PRESCALE advances
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic adv,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic w_unused;
            assign w_unused = clk ^ rst ^ clear;
            assign tick     = adv;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] r_phase;

            // Phase only moves on adv, so a pause keeps its place in the cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_phase <= '0;
                end else if (clear) begin
                    r_phase <= '0;
                end else if (adv) begin
                    if (r_phase == LAST) begin
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
            end

            assign tick = adv & (r_phase == LAST);
        end
    endgenerate

endmodule

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down counter with load, wrap/stop, pause and prescaled enable
module mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 13,
    parameter int MAXCOUNT = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             en,
    input  logic             hold,
    input  logic             dir,
    input  logic             wrap,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAXCOUNT);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;

    logic             w_adv;
    logic             w_tick;
    logic [WIDTH-1:0] w_load;

    assign w_adv  = en & ~hold & (r_state == RUN);
    assign w_load = (load_val > MAXV) ? MAXV : load_val;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(go),
        .adv  (w_adv),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (go) begin
                r_state <= RUN;
                r_count <= w_load;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (hold) begin
                            r_state <= PAUSE;
                        end else if (w_tick) begin
                            if (dir == DIR_UP) begin
                                if (r_count < MAXV) begin
                                    r_count <= r_count + 1'b1;
                                end else begin
                                    r_tc <= 1'b1;
                                    if (wrap) begin
                                        r_count <= '0;
                                    end else begin
                                        r_state <= DONE;
                                        r_done  <= 1'b1;
                                    end
                                end
                            end else begin
                                if (r_count != '0) begin
                                    r_count <= r_count - 1'b1;
                                end else begin
                                    r_tc <= 1'b1;
                                    if (wrap) begin
                                        r_count <= MAXV;
                                    end else begin
                                        r_state <= DONE;
                                        r_done  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (!hold) begin
                            r_state <= RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign done    = r_done;
    assign running = (r_state == RUN);

endmodule
